// File: rtl/gcd_pkg.sv
// Shared definitions for the APB GCD queue engine: register offsets,
// CTRL/STATUS bit positions and the core state encoding.
package gcd_pkg;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_OPA    = 8'h08;
    localparam logic [7:0] OFF_OPB    = 8'h0C;
    localparam logic [7:0] OFF_RESULT = 8'h10;
    localparam logic [7:0] OFF_CYCLES = 8'h14;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_FLUSH  = 2;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_CMD_FULL  = 1;
    localparam int STAT_CMD_EMPTY = 2;
    localparam int STAT_RES_FULL  = 3;
    localparam int STAT_RES_EMPTY = 4;
    localparam int STAT_CMD_CNT   = 8;
    localparam int STAT_RES_CNT   = 16;

    typedef enum logic [1:0] {
        CORE_IDLE,
        CORE_LOAD,
        CORE_RUN,
        CORE_DONE
    } core_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/gcd_stein_core.sv
// Binary (Stein) GCD engine, one reduction step per RUN cycle.
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  IDLE  | waiting; pops a command when start is high
//  LOAD  | operands captured, one settling cycle before stepping
//  RUN   | one Stein step per cycle, counting cycles
//  DONE  | result ready; held until the result FIFO has room
module gcd_stein_core
    import gcd_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clken,
    input  logic              flush,
    input  logic              start,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              ready,
    output logic              cmd_pop,
    output logic              done,
    output logic              busy,
    output logic [DATA_W-1:0] result,
    output logic [31:0]       cycles
);

    localparam int KW = $clog2(DATA_W) + 1;

    core_state_t       state, state_nxt;
    logic [DATA_W-1:0] a, b;
    logic [KW-1:0]     k;
    logic [31:0]       run_cnt;
    logic              zero_op;

    assign zero_op = (a == '0) || (b == '0);
    assign busy    = (state != CORE_IDLE);

    // State register; flush abandons any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= CORE_IDLE;
        else if (clken)
            state <= flush ? CORE_IDLE : state_nxt;
    end

    // Next state plus the FIFO pop/push strobes.
    always_comb begin
        state_nxt = state;
        cmd_pop   = 1'b0;
        done      = 1'b0;
        case (state)
            CORE_IDLE: if (start) begin
                cmd_pop   = 1'b1;
                state_nxt = CORE_LOAD;
            end
            CORE_LOAD: state_nxt = CORE_RUN;
            CORE_RUN:  if (zero_op) state_nxt = CORE_DONE;
            CORE_DONE: if (ready) begin
                done      = 1'b1;
                state_nxt = CORE_IDLE;
            end
            default:   state_nxt = CORE_IDLE;
        endcase
        if (!clken || flush) begin
            cmd_pop = 1'b0;
            done    = 1'b0;
        end
    end

    // Operand datapath, shift exponent and cycle counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a       <= '0;
            b       <= '0;
            k       <= '0;
            run_cnt <= '0;
            result  <= '0;
            cycles  <= '0;
        end else if (clken) begin
            if (flush) begin
                cycles <= '0;
            end else begin
                case (state)
                    CORE_IDLE: if (start) begin
                        a       <= op_a;
                        b       <= op_b;
                        k       <= '0;
                        run_cnt <= '0;
                    end
                    CORE_RUN: begin
                        run_cnt <= sat_inc(run_cnt);
                        if (zero_op) begin
                            result <= (a | b) << k;
                            cycles <= sat_inc(run_cnt);
                        end else if (!a[0] && !b[0]) begin
                            a <= a >> 1;
                            b <= b >> 1;
                            k <= k + KW'(1);
                        end else if (!a[0]) begin
                            a <= a >> 1;
                        end else if (!b[0]) begin
                            b <= b >> 1;
                        end else if (a >= b) begin
                            a <= (a - b) >> 1;
                        end else begin
                            b <= (b - a) >> 1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/gcd_apb_queue_engine.sv
// APB front end for the GCD engine: register decode, command FIFO,
// result FIFO and the level interrupt.
module gcd_apb_queue_engine
    import gcd_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CLKEN,
    input  logic [31:0] S_APB_PADDR,
    input  logic        S_APB_PSEL,
    input  logic        S_APB_PENABLE,
    input  logic        S_APB_PWRITE,
    input  logic [31:0] S_APB_PWDATA,
    output logic [31:0] S_APB_PRDATA,
    output logic        S_APB_PREADY,
    output logic        S_APB_PSLVERR,
    output logic        IRQ
);

    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);

    logic                en, irq_en, irq_q;
    logic [DATA_W-1:0]   opa;
    logic                access, flush, ctrl_we, opa_we, cmd_push, res_pop;
    logic [31:0]         status, prdata_c;
    logic                slverr_c;

    logic [2*DATA_W-1:0] cmd_mem [CMD_DEPTH];
    logic [CAW-1:0]      cmd_wp, cmd_rp;
    logic [CAW:0]        cmd_cnt;
    logic                cmd_full, cmd_empty, cmd_pop;

    logic [DATA_W-1:0]   res_mem [RES_DEPTH];
    logic [RAW-1:0]      res_wp, res_rp;
    logic [RAW:0]        res_cnt;
    logic                res_full, res_empty, res_push;

    logic                core_busy;
    logic [DATA_W-1:0]   core_result;
    logic [31:0]         core_cycles;
    logic [2*DATA_W-1:0] cmd_head;
    logic                unused_bits;

    assign unused_bits  = ^{S_APB_PADDR[31:8], S_APB_PWDATA};
    assign access       = S_APB_PSEL & S_APB_PENABLE & CLKEN;
    assign cmd_full     = (cmd_cnt == (CAW+1)'(CMD_DEPTH));
    assign cmd_empty    = (cmd_cnt == '0);
    assign res_full     = (res_cnt == (RAW+1)'(RES_DEPTH));
    assign res_empty    = (res_cnt == '0);
    assign cmd_head     = cmd_mem[cmd_rp];
    assign S_APB_PREADY = 1'b1;
    assign S_APB_PRDATA = prdata_c;
    assign S_APB_PSLVERR = slverr_c;
    assign IRQ          = irq_q;

    gcd_stein_core #(.DATA_W(DATA_W)) u_core (
        .clk     (CLK),
        .rst     (RESET),
        .clken   (CLKEN),
        .flush   (flush),
        .start   (en & ~cmd_empty),
        .op_a    (cmd_head[2*DATA_W-1:DATA_W]),
        .op_b    (cmd_head[DATA_W-1:0]),
        .ready   (~res_full),
        .cmd_pop (cmd_pop),
        .done    (res_push),
        .busy    (core_busy),
        .result  (core_result),
        .cycles  (core_cycles)
    );

    // Register decode: read mux, error response and one-shot side-effect strobes.
    always_comb begin
        status   = '0;
        prdata_c = '0;
        slverr_c = 1'b0;
        flush    = 1'b0;
        ctrl_we  = 1'b0;
        opa_we   = 1'b0;
        cmd_push = 1'b0;
        res_pop  = 1'b0;
        status[STAT_BUSY]                = core_busy;
        status[STAT_CMD_FULL]            = cmd_full;
        status[STAT_CMD_EMPTY]           = cmd_empty;
        status[STAT_RES_FULL]            = res_full;
        status[STAT_RES_EMPTY]           = res_empty;
        status[STAT_CMD_CNT +: CAW+1]    = cmd_cnt;
        status[STAT_RES_CNT +: RAW+1]    = res_cnt;
        if (access) begin
            case (S_APB_PADDR[7:0])
                OFF_CTRL:
                    if (S_APB_PWRITE) begin
                        ctrl_we = 1'b1;
                        flush   = S_APB_PWDATA[CTRL_FLUSH];
                    end else begin
                        prdata_c[CTRL_EN]     = en;
                        prdata_c[CTRL_IRQ_EN] = irq_en;
                    end
                OFF_STATUS:
                    if (S_APB_PWRITE) slverr_c = 1'b1;
                    else              prdata_c = status;
                OFF_OPA:
                    if (S_APB_PWRITE) opa_we = 1'b1;
                    else              prdata_c[DATA_W-1:0] = opa;
                OFF_OPB:
                    if (S_APB_PWRITE) begin
                        if (cmd_full) slverr_c = 1'b1;
                        else          cmd_push = 1'b1;
                    end
                OFF_RESULT:
                    if (S_APB_PWRITE || res_empty) begin
                        slverr_c = 1'b1;
                    end else begin
                        prdata_c[DATA_W-1:0] = res_mem[res_rp];
                        res_pop              = 1'b1;
                    end
                OFF_CYCLES:
                    if (S_APB_PWRITE) slverr_c = 1'b1;
                    else              prdata_c = core_cycles;
                default: slverr_c = 1'b1;
            endcase
        end
    end

    // Control bits, operand A staging and the registered interrupt.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            en     <= 1'b0;
            irq_en <= 1'b0;
            opa    <= '0;
            irq_q  <= 1'b0;
        end else if (CLKEN) begin
            if (ctrl_we) begin
                en     <= S_APB_PWDATA[CTRL_EN];
                irq_en <= S_APB_PWDATA[CTRL_IRQ_EN];
            end
            if (opa_we)
                opa <= S_APB_PWDATA[DATA_W-1:0];
            irq_q <= irq_en & ~res_empty;
        end
    end

    // Command FIFO storage; the push strobe already carries CLKEN and fullness.
    always_ff @(posedge CLK) begin
        if (cmd_push)
            cmd_mem[cmd_wp] <= {opa, S_APB_PWDATA[DATA_W-1:0]};
    end

    // Command FIFO pointers and occupancy.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cmd_wp  <= '0;
            cmd_rp  <= '0;
            cmd_cnt <= '0;
        end else if (CLKEN) begin
            if (flush) begin
                cmd_wp  <= '0;
                cmd_rp  <= '0;
                cmd_cnt <= '0;
            end else begin
                if (cmd_push) cmd_wp <= cmd_wp + CAW'(1);
                if (cmd_pop)  cmd_rp <= cmd_rp + CAW'(1);
                if (cmd_push && !cmd_pop)      cmd_cnt <= cmd_cnt + (CAW+1)'(1);
                else if (!cmd_push && cmd_pop) cmd_cnt <= cmd_cnt - (CAW+1)'(1);
            end
        end
    end

    // Result FIFO storage; the core only pushes when there is room.
    always_ff @(posedge CLK) begin
        if (res_push)
            res_mem[res_wp] <= core_result;
    end

    // Result FIFO pointers and occupancy.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            res_wp  <= '0;
            res_rp  <= '0;
            res_cnt <= '0;
        end else if (CLKEN) begin
            if (flush) begin
                res_wp  <= '0;
                res_rp  <= '0;
                res_cnt <= '0;
            end else begin
                if (res_push) res_wp <= res_wp + RAW'(1);
                if (res_pop)  res_rp <= res_rp + RAW'(1);
                if (res_push && !res_pop)      res_cnt <= res_cnt + (RAW+1)'(1);
                else if (!res_push && res_pop) res_cnt <= res_cnt - (RAW+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_gcd_apb_queue_engine.sv
// Scoreboard bench: stimulus queues expected GCDs, a monitor checks every
// successful RESULT read against the head of that queue.
module tb_gcd_apb_queue_engine;

    logic        clk = 1'b0;
    logic        rst, clken;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready, pslverr, irq;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    logic [31:0] d;
    logic        e;

    always #5 clk = ~clk;

    gcd_apb_queue_engine #(.DATA_W(32), .CMD_DEPTH(4), .RES_DEPTH(4)) dut (
        .CLK           (clk),
        .RESET         (rst),
        .CLKEN         (clken),
        .S_APB_PADDR   (paddr),
        .S_APB_PSEL    (psel),
        .S_APB_PENABLE (penable),
        .S_APB_PWRITE  (pwrite),
        .S_APB_PWDATA  (pwdata),
        .S_APB_PRDATA  (prdata),
        .S_APB_PREADY  (pready),
        .S_APB_PSLVERR (pslverr),
        .IRQ           (irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [31:0] dat, output logic err);
        @(posedge clk); #1;
        paddr = {24'h0, a}; pwrite = 1'b1; pwdata = dat; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_rd(input logic [7:0] a, output logic [31:0] dat, output logic err);
        @(posedge clk); #1;
        paddr = {24'h0, a}; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        dat = prdata;
        err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input logic exp_err,
                             input logic keep, input logic [31:0] r);
        logic err;
        apb_wr(8'h08, a, err);
        apb_wr(8'h0C, b, err);
        chk("opb_pslverr", {31'b0, err}, {31'b0, exp_err});
        if (keep) exp_q.push_back(r);
    endtask

    task automatic wait_res(input int n);
        logic [31:0] s;
        logic        err;
        s = '0;
        for (int i = 0; i < 100; i++) begin
            apb_rd(8'h04, s, err);
            if (s[23:16] == n[7:0]) break;
        end
        chk("wait_res_count", {24'b0, s[23:16]}, n);
    endtask

    // Monitor: every RESULT read that returns data is checked against the scoreboard.
    always @(negedge clk) begin
        if (psel && penable && !pwrite && paddr[7:0] == 8'h10 && clken && !pslverr) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL result_unexpected: got 0x%08h, expected no result", prdata);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("result", prdata, mon_exp);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; clken = 1'b1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_pslverr", {31'b0, pslverr}, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        apb_rd(8'h04, d, e); chk("rst_status", d, 32'h0000_0014);
        apb_rd(8'h00, d, e); chk("rst_ctrl", d, 32'h0);
        apb_rd(8'h14, d, e); chk("rst_cycles", d, 32'h0);

        // 48,18 -> 6 in 7 RUN cycles
        apb_wr(8'h00, 32'h1, e);
        push_pair(48, 18, 1'b0, 1'b1, 6);
        wait_res(1);
        apb_rd(8'h14, d, e); chk("cycles_48_18", d, 32'd7);
        apb_rd(8'h10, d, e);
        apb_rd(8'h04, d, e); chk("status_after_t1", d, 32'h0000_0014);

        // zero operands
        push_pair(0, 7, 1'b0, 1'b1, 7);
        push_pair(7, 0, 1'b0, 1'b1, 7);
        push_pair(0, 0, 1'b0, 1'b1, 0);
        wait_res(3);
        apb_rd(8'h14, d, e); chk("cycles_0_0", d, 32'd1);
        for (int i = 0; i < 3; i++) apb_rd(8'h10, d, e);

        // 32-bit extremes
        push_pair(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1, 1);
        wait_res(1);
        apb_rd(8'h14, d, e); chk("cycles_ffff", d, 32'd64);
        chk("cycles_ffff_le65", {31'b0, (d <= 32'd65)}, 32'h1);
        apb_rd(8'h10, d, e);
        push_pair(32'h8000_0000, 32'h4000_0000, 1'b0, 1'b1, 32'h4000_0000);
        wait_res(1);
        apb_rd(8'h14, d, e); chk("cycles_pow2", d, 32'd33);
        apb_rd(8'h10, d, e);

        // command FIFO overflow, then result FIFO back-pressure
        apb_wr(8'h00, 32'h0, e);
        push_pair(12, 8, 1'b0, 1'b1, 4);
        push_pair(9, 6, 1'b0, 1'b1, 3);
        push_pair(35, 14, 1'b0, 1'b1, 7);
        push_pair(100, 75, 1'b0, 1'b1, 25);
        push_pair(1, 1, 1'b1, 1'b0, 0);
        apb_rd(8'h04, d, e); chk("status_cmd_full", d, 32'h0000_0412);
        apb_wr(8'h00, 32'h1, e);
        wait_res(4);
        apb_rd(8'h04, d, e); chk("status_res_full", d, 32'h0004_000C);
        push_pair(2, 4, 1'b0, 1'b1, 2);
        repeat (30) @(posedge clk);
        apb_rd(8'h04, d, e); chk("status_done_stall", d, 32'h0004_000D);
        apb_rd(8'h10, d, e);
        wait_res(4);
        apb_rd(8'h14, d, e); chk("cycles_2_4", d, 32'd4);
        for (int i = 0; i < 4; i++) apb_rd(8'h10, d, e);
        apb_rd(8'h04, d, e); chk("status_drained", d, 32'h0000_0014);

        // error responses
        apb_rd(8'h10, d, e);
        chk("empty_result_err", {31'b0, e}, 32'h1);
        chk("empty_result_data", d, 32'h0);
        apb_rd(8'h18, d, e); chk("unmapped_err", {31'b0, e}, 32'h1);
        apb_wr(8'h04, 32'hFFFF_FFFF, e); chk("ro_write_err", {31'b0, e}, 32'h1);
        apb_rd(8'h04, d, e); chk("status_after_ro_write", d, 32'h0000_0014);
        apb_rd(8'h0C, d, e);
        chk("opb_read_data", d, 32'h0);
        chk("opb_read_err", {31'b0, e}, 32'h0);
        apb_rd(8'h08, d, e); chk("opa_readback", d, 32'd2);

        // IRQ timing: push lands 4 cycles after the OPB write, IRQ one cycle later
        apb_wr(8'h00, 32'h3, e);
        push_pair(0, 5, 1'b0, 1'b1, 5);
        repeat (4) @(posedge clk);
        @(negedge clk); chk("irq_before", {31'b0, irq}, 32'h0);
        @(negedge clk); chk("irq_after", {31'b0, irq}, 32'h1);
        apb_rd(8'h10, d, e);
        repeat (2) @(negedge clk);
        chk("irq_cleared", {31'b0, irq}, 32'h0);

        // FLUSH mid-RUN
        push_pair(32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0, 0);
        push_pair(9, 6, 1'b0, 1'b0, 0);
        repeat (10) @(posedge clk);
        apb_rd(8'h04, d, e); chk("status_pre_flush", d, 32'h0000_0111);
        apb_wr(8'h00, 32'h7, e);
        apb_rd(8'h04, d, e); chk("status_post_flush", d, 32'h0000_0014);
        repeat (60) @(posedge clk);
        apb_rd(8'h04, d, e); chk("status_flush_settled", d, 32'h0000_0014);
        chk("irq_flush", {31'b0, irq}, 32'h0);
        apb_rd(8'h14, d, e); chk("cycles_flushed", d, 32'h0);
        apb_rd(8'h00, d, e); chk("ctrl_kept", d, 32'h3);

        // RESET mid-RUN
        push_pair(32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0, 0);
        repeat (10) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk); chk("irq_reset", {31'b0, irq}, 32'h0);
        apb_rd(8'h04, d, e); chk("status_reset", d, 32'h0000_0014);
        apb_rd(8'h00, d, e); chk("ctrl_reset", d, 32'h0);
        apb_rd(8'h08, d, e); chk("opa_reset", d, 32'h0);

        // CLKEN=0 freezes APB and the core
        push_pair(21, 14, 1'b0, 1'b1, 7);
        @(negedge clk); clken = 1'b0;
        apb_wr(8'h00, 32'h3, e);
        apb_wr(8'h0C, 32'h5, e);
        repeat (20) @(posedge clk);
        @(negedge clk); clken = 1'b1;
        apb_rd(8'h04, d, e); chk("status_clken_apb", d, 32'h0000_0110);
        apb_rd(8'h00, d, e); chk("ctrl_clken_apb", d, 32'h0);
        apb_wr(8'h00, 32'h1, e);
        @(posedge clk); @(posedge clk); #1 clken = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk); clken = 1'b1;
        apb_rd(8'h04, d, e); chk("status_clken_core", d, 32'h0000_0015);
        wait_res(1);
        apb_rd(8'h10, d, e);

        chk("scoreboard_empty", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
